// File: rtl/iic_arbiter.sv
// Round-robin arbiter that lends one iic_core's tx/rx FIFOs to one of NREQ requesters per transaction.
// After release it waits for the bus engine to finish and flushes leftover rx bytes before re-arbitrating.
module iic_arbiter #(
    parameter int NREQ          = 4,
    parameter int GRANT_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [2:0]      gnt_id,
    input  logic [NREQ-1:0] tx_wr,
    input  logic [NREQ*8-1:0] tx_din,
    output logic            tx_full,
    input  logic [NREQ-1:0] rx_rd,
    output logic [7:0]      rx_dout,
    output logic            rx_empty,
    output logic            busy,
    output logic            timeout,
    output logic            drop_err,
    output logic            core_tx_fifo_wr,
    output logic [7:0]      core_tx_fifo_din,
    input  logic            core_tx_fifo_full,
    input  logic            core_tx_fifo_empty,
    output logic            core_rx_fifo_rd,
    input  logic [7:0]      core_rx_fifo_dout,
    input  logic            core_rx_fifo_empty,
    input  logic            core_idle
);

    localparam int CNT_W = $clog2(GRANT_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, OWN, DRAIN, FLUSH} state_t;

    state_t           state;
    state_t           state_n;
    logic [2:0]       rr_ptr;
    logic [2:0]       winner;
    logic [2:0]       idx;
    logic             found;
    logic [CNT_W-1:0] cnt;
    logic             wrote;
    logic             tmo_hit;
    logic [7:0]       req_w;
    logic [7:0]       tx_wr_w;
    logic [7:0]       rx_rd_w;
    logic [63:0]      tx_din_w;
    logic             own_req;
    logic             own_wr;
    logic             own_rd;

    // Pad per-requester vectors to 8 so a 3-bit owner index selects them exactly.
    assign req_w    = 8'(req);
    assign tx_wr_w  = 8'(tx_wr);
    assign rx_rd_w  = 8'(rx_rd);
    assign tx_din_w = 64'(tx_din);

    assign own_req = req_w[gnt_id];
    assign own_wr  = tx_wr_w[gnt_id];
    assign own_rd  = rx_rd_w[gnt_id];

    assign gnt              = (state == OWN) ? NREQ'(8'd1 << gnt_id) : '0;
    assign busy             = (state != IDLE);
    assign tx_full          = (state == OWN) ? core_tx_fifo_full : 1'b1;
    assign rx_empty         = (state == OWN) ? core_rx_fifo_empty : 1'b1;
    assign rx_dout          = core_rx_fifo_dout;
    assign core_tx_fifo_din = tx_din_w[{gnt_id, 3'b000} +: 8];

    // First requester at or above rr_ptr, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = 3'((int'(rr_ptr) + i) % NREQ);
            if (!found && req_w[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_n         = state;
        core_tx_fifo_wr = 1'b0;
        core_rx_fifo_rd = 1'b0;
        tmo_hit         = 1'b0;
        case (state)
            IDLE: begin
                if (found) state_n = OWN;
            end
            OWN: begin
                core_tx_fifo_wr = own_wr & ~core_tx_fifo_full;
                core_rx_fifo_rd = own_rd & ~core_rx_fifo_empty;
                // A voluntary release wins over a timeout in the same cycle.
                if (!own_req) begin
                    state_n = DRAIN;
                end else if (!wrote && !core_tx_fifo_wr &&
                             cnt == CNT_W'(GRANT_TIMEOUT - 1)) begin
                    tmo_hit = 1'b1;
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (core_tx_fifo_empty && core_idle) state_n = FLUSH;
            end
            FLUSH: begin
                core_rx_fifo_rd = ~core_rx_fifo_empty;
                if (core_rx_fifo_empty) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_id   <= '0;
            rr_ptr   <= '0;
            cnt      <= '0;
            wrote    <= 1'b0;
            timeout  <= 1'b0;
            drop_err <= 1'b0;
        end else begin
            timeout  <= tmo_hit;
            drop_err <= (state == OWN) && own_wr && core_tx_fifo_full;
            if (state == IDLE && found) begin
                gnt_id <= winner;
                cnt    <= '0;
                wrote  <= 1'b0;
            end else if (state == OWN) begin
                // The first accepted write freezes the counter for the rest of the grant.
                if (core_tx_fifo_wr)  wrote <= 1'b1;
                else if (!wrote)      cnt   <= cnt + CNT_W'(1);
            end
            if (state == FLUSH && core_rx_fifo_empty)
                rr_ptr <= (gnt_id == 3'(NREQ - 1)) ? 3'd0 : gnt_id + 3'd1;
        end
    end

endmodule
